// File: rtl/uart_tx_pkg.sv
// Shared register map, STATUS/CTRL layout and FSM state type for the UART transmitter.
// The base address is consumed by the CPU address decoder to raise weUart.
package uart_tx_pkg;

  localparam logic [31:0] UART_BASE_ADDR = 32'h0000_4010;

  localparam logic [1:0] UART_REG_DATA   = 2'd0;
  localparam logic [1:0] UART_REG_STATUS = 2'd1;
  localparam logic [1:0] UART_REG_DIV    = 2'd2;
  localparam logic [1:0] UART_REG_CTRL   = 2'd3;

  localparam int STAT_OVF    = 3;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

  // Lower half of the STATUS word, MSB first
  typedef struct packed {
    logic [7:0] count;
    logic [3:0] rsvd;
    logic       ovf;
    logic       busy;
    logic       empty;
    logic       full;
  } status_t;

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Single-clock FIFO with occupancy count; shared by the UART transmit and receive paths.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS/DIV/CTRL registers, transmit FIFO, serialiser FSM.
// The read-data port is dout because "do" is a reserved word.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  regSel,
  input  logic        we,
  input  logic [31:0] di,
  output logic [31:0] dout,
  output logic        txd,
  output logic        irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]   div, reload, cnt;
  logic          enable, irq_en, ovf;
  logic          fifo_full, fifo_empty, push, pop;
  logic [7:0]    fifo_dout, shift;
  logic [CW-1:0] fifo_count;
  logic [2:0]    bit_idx;
  tx_state_t     state;
  status_t       status;
  logic          unused;

  assign unused = ^di[31:16];
  assign push   = we && (regSel == UART_REG_DATA);
  assign pop    = (state == S_IDLE) && enable && !fifo_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (di[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A DATA write against a full FIFO is lost and latched as overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      div    <= 16'(DEFAULT_DIV);
      enable <= 1'b1;
      irq_en <= 1'b0;
      ovf    <= 1'b0;
    end else if (we) begin
      case (regSel)
        UART_REG_DATA:   if (fifo_full) ovf <= 1'b1;
        UART_REG_STATUS: if (di[STAT_OVF]) ovf <= 1'b0;
        UART_REG_DIV:    div <= (di[15:0] == 16'd0) ? 16'd1 : di[15:0];
        UART_REG_CTRL: begin
          enable <= di[CTRL_EN];
          irq_en <= di[CTRL_IRQ_EN];
        end
      endcase
    end
  end

  always_comb begin
    status       = '0;
    status.count = 8'(fifo_count);
    status.ovf   = ovf;
    status.busy  = (state != S_IDLE);
    status.empty = fifo_empty;
    status.full  = fifo_full;
  end

  always_comb begin
    dout = '0;
    case (regSel)
      UART_REG_STATUS: dout = {16'd0, status};
      UART_REG_DIV:    dout = {16'd0, div};
      UART_REG_CTRL:   dout = {30'd0, irq_en, enable};
      default:         dout = '0;
    endcase
  end

  // txd and irq are registered from the pre-edge state, so the line trails the FSM by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      txd     <= 1'b1;
      irq     <= 1'b0;
      cnt     <= '0;
      reload  <= '0;
      shift   <= '0;
      bit_idx <= '0;
    end else begin
      txd <= (state == S_START) ? 1'b0 : (state == S_DATA) ? shift[0] : 1'b1;
      irq <= irq_en && fifo_empty && (state == S_IDLE);
      case (state)
        S_IDLE: if (enable && !fifo_empty) begin
          state   <= S_START;
          shift   <= fifo_dout;
          reload  <= div;
          cnt     <= div - 16'd1;
          bit_idx <= '0;
        end
        S_START: if (cnt == '0) begin
          state <= S_DATA;
          cnt   <= reload - 16'd1;
        end else cnt <= cnt - 16'd1;
        S_DATA: if (cnt == '0) begin
          cnt <= reload - 16'd1;
          if (bit_idx == 3'd7) state <= S_STOP;
          else begin
            bit_idx <= bit_idx + 3'd1;
            shift   <= shift >> 1;
          end
        end else cnt <= cnt - 16'd1;
        S_STOP: if (cnt == '0) state <= S_IDLE;
          else cnt <= cnt - 16'd1;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: stimulus queues expected bytes, a line monitor decodes txd frames.
module tb_uart_tx;
  import uart_tx_pkg::*;

  logic        clk, reset, we, txd, irq;
  logic [1:0]  regSel;
  logic [31:0] di, dout;

  int checks = 0, errors = 0, cyc = 0, frames_seen = 0;
  bit mon_en = 1'b0;

  typedef struct {logic [7:0] data; int div;} exp_t;
  exp_t sbq[$];
  int   starts[$];

  uart_tx #(.FIFO_DEPTH(8), .DEFAULT_DIV(434)) dut (
    .clk(clk), .reset(reset), .regSel(regSel), .we(we), .di(di),
    .dout(dout), .txd(txd), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp_v, cyc);
    end
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] v);
    @(negedge clk);
    regSel = sel; di = v; we = 1'b1;
    @(negedge clk);
    we = 1'b0; di = '0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] sel, input logic [31:0] exp_v);
    regSel = sel;
    #1;
    chk(name, dout, exp_v);
  endtask

  task automatic send(input logic [7:0] b, input int d);
    exp_t e;
    e.data = b; e.div = d;
    sbq.push_back(e);
    wr(UART_REG_DATA, {24'd0, b});
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (frames_seen < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("frames_done", frames_seen, n);
  endtask

  // Line monitor: decodes one 8N1 frame, requiring every bit to hold steady for its full length
  initial begin : mon
    logic prev;
    logic [7:0] got;
    exp_t e;
    bit bad;
    int d, st;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev === 1'b1 && txd === 1'b0) begin
        st = cyc; bad = 1'b0; got = '0;
        chk("sb_nonempty", 32'(sbq.size() != 0), 1);
        if (sbq.size() != 0) e = sbq.pop_front();
        else begin e.data = 'x; e.div = 1; end
        d = e.div;
        for (int k = 1; k < d; k++) begin
          @(negedge clk);
          if (txd !== 1'b0) bad = 1'b1;
        end
        for (int b = 0; b < 8; b++)
          for (int k = 0; k < d; k++) begin
            @(negedge clk);
            if (k == 0) got[b] = txd;
            else if (txd !== got[b]) bad = 1'b1;
          end
        for (int k = 0; k < d; k++) begin
          @(negedge clk);
          if (txd !== 1'b1) bad = 1'b1;
        end
        chk("frame_data", {24'd0, got}, {24'd0, e.data});
        chk("frame_timing", 32'(bad), 0);
        starts.push_back(st);
        frames_seen++;
        prev = 1'b1;
      end else prev = txd;
    end
  end

  initial begin
    int w;
    reset = 1'b1; we = 1'b0; regSel = '0; di = '0;
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd), 1);
    chk("rst_irq", 32'(irq), 0);
    rd_chk("rst_status", UART_REG_STATUS, 32'h0000_0002);
    rd_chk("rst_div", UART_REG_DIV, 32'd434);
    rd_chk("rst_ctrl", UART_REG_CTRL, 32'h1);
    rd_chk("rst_data", UART_REG_DATA, 32'h0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Single frame, DIV=4
    wr(UART_REG_DIV, 32'd4);
    send(8'h55, 4);
    w = cyc;
    wait_frames(1, 100);
    chk("t1_start", starts[0], w + 2);
    rd_chk("t1_idle", UART_REG_STATUS, 32'h0000_0002);

    // Two queued frames, DIV=2, released together
    wr(UART_REG_DIV, 32'd2);
    wr(UART_REG_CTRL, 32'h0);
    send(8'hA5, 2);
    send(8'h3C, 2);
    wr(UART_REG_CTRL, 32'h1);
    rd_chk("t2_cnt2", UART_REG_STATUS, 32'h0000_0200);
    @(negedge clk);
    rd_chk("t2_cnt1", UART_REG_STATUS, 32'h0000_0104);
    wait_frames(3, 120);
    chk("t2_gap", starts[2] - starts[1], 21);
    rd_chk("t2_cnt0", UART_REG_STATUS, 32'h0000_0002);

    // Overflow with transmitter disabled
    wr(UART_REG_CTRL, 32'h0);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) send(8'h10 + 8'(i), 2);
      else wr(UART_REG_DATA, 32'h0000_00EE);
    end
    rd_chk("t3_full_ovf", UART_REG_STATUS, 32'h0000_0809);
    wr(UART_REG_STATUS, 32'h8);
    rd_chk("t3_ovf_clr", UART_REG_STATUS, 32'h0000_0801);
    wr(UART_REG_CTRL, 32'h1);
    wait_frames(11, 400);
    repeat (40) @(negedge clk);
    chk("t3_no_9th", frames_seen, 11);
    chk("t3_sb_drained", sbq.size(), 0);
    rd_chk("t3_empty", UART_REG_STATUS, 32'h0000_0002);

    // DIV=0 clamps to 1; mid-frame DIV change applies to the next frame only
    wr(UART_REG_DIV, 32'd0);
    rd_chk("t4_div1", UART_REG_DIV, 32'd1);
    send(8'hFF, 1);
    w = cyc;
    send(8'h5A, 3);
    rd_chk("t4_pushpop", UART_REG_STATUS, 32'h0000_0104);
    wr(UART_REG_DIV, 32'd3);
    rd_chk("t4_div3", UART_REG_DIV, 32'd3);
    wait_frames(13, 120);
    chk("t4_start", starts[11], w + 2);
    chk("t4_gap", starts[12] - starts[11], 11);

    // Interrupt around one frame
    wr(UART_REG_CTRL, 32'h3);
    @(negedge clk);
    chk("t5_irq_idle", 32'(irq), 1);
    send(8'hC3, 3);
    w = cyc;
    while (cyc < w + 10) @(negedge clk);
    chk("t5_irq_mid", 32'(irq), 0);
    while (cyc < w + 2 + 29) @(negedge clk);
    chk("t5_irq_stop", 32'(irq), 0);
    @(negedge clk);
    chk("t5_irq_rise", 32'(irq), 1);
    wait_frames(14, 60);

    // Reset in the middle of the data bits
    mon_en = 1'b0;
    wr(UART_REG_DATA, 32'h0000_0081);
    w = cyc;
    while (cyc < w + 14) @(negedge clk);
    chk("t6_pre_low", 32'(txd === 1'b0 || txd === 1'b1), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_txd", 32'(txd), 1);
    chk("t6_irq", 32'(irq), 0);
    rd_chk("t6_status", UART_REG_STATUS, 32'h0000_0002);
    rd_chk("t6_div", UART_REG_DIV, 32'd434);
    rd_chk("t6_ctrl", UART_REG_CTRL, 32'h1);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    mon_en = 1'b1;
    repeat (60) @(negedge clk);
    chk("t6_quiet", frames_seen, 14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
